// File: rtl/rgb_pkg.sv
// Shared constants for RGB/RGBW pixel-word handling and one-wire LED bit timing.
package rgb_pkg;

  // Pixel word layout: [31] valid, [30] stream reset, [29:24] ignored, then G, R, B bytes.
  localparam int unsigned WORD_VALID_BIT    = 31;
  localparam int unsigned WORD_STRM_RST_BIT = 30;
  localparam int unsigned WORD_G_MSB        = 23;
  localparam int unsigned WORD_G_LSB        = 16;
  localparam int unsigned WORD_R_MSB        = 15;
  localparam int unsigned WORD_R_LSB        = 8;
  localparam int unsigned WORD_B_MSB        = 7;
  localparam int unsigned WORD_B_LSB        = 0;

  // Output encodings.
  localparam int unsigned OUT_MODE_GRB          = 0;  // 24-bit GRB pass-through
  localparam int unsigned OUT_MODE_GRBW_EXTRACT = 1;  // 32-bit GRBW, W = min(R,G,B)
  localparam int unsigned OUT_MODE_GRBW_ZERO    = 2;  // 32-bit GRBW, W = 0

  // Default bit timing in clocks at 96 MHz.
  localparam int unsigned DEF_T0H               = 16;
  localparam int unsigned DEF_T0L               = 74;
  localparam int unsigned DEF_T1H               = 45;
  localparam int unsigned DEF_T1L               = 45;
  localparam int unsigned DEF_STREAM_RESET_CLKS = 7681;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StConvert,
    StSendH,
    StSendL,
    StStrmRst
  } sotp_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rgbw_sotp_gen_if.sv
// FIFO read port and LED strip output of the serial pixel driver.
interface rgbw_sotp_gen_if;
  logic        in_rd_fifo_empty;
  logic [31:0] in_rd_fifo_data;
  logic        out_rd_fifo_en;
  logic        out_sig;
  logic        out_busy;
  logic        out_pixel_done;

  // Driver side.
  modport master (
    input  in_rd_fifo_empty,
    input  in_rd_fifo_data,
    output out_rd_fifo_en,
    output out_sig,
    output out_busy,
    output out_pixel_done
  );

  // FIFO / strip side.
  modport slave (
    output in_rd_fifo_empty,
    output in_rd_fifo_data,
    input  out_rd_fifo_en,
    input  out_sig,
    input  out_busy,
    input  out_pixel_done
  );
endinterface

// File: rtl/rgbw_white_extract.sv
// Combinational white extraction: W = min(R,G,B), subtracted from each colour.
// With i_en low the colours pass through unchanged and W is zero.
module rgbw_white_extract (
  input  logic       i_en,
  input  logic [7:0] i_g,
  input  logic [7:0] i_r,
  input  logic [7:0] i_b,
  output logic [7:0] o_g,
  output logic [7:0] o_r,
  output logic [7:0] o_b,
  output logic [7:0] o_w
);

  logic [7:0] w_min_gr;
  logic [7:0] w_min;

  // Minimum of the three channels; subtracting it can never underflow.
  always_comb begin
    w_min_gr = (i_g < i_r) ? i_g : i_r;
    w_min    = (w_min_gr < i_b) ? w_min_gr : i_b;
    o_w      = i_en ? w_min : 8'h00;
    o_g      = i_g - o_w;
    o_r      = i_r - o_w;
    o_b      = i_b - o_w;
  end

endmodule

// File: rtl/rgbw_sotp_gen.sv
// Serial one-wire LED driver: pops pixel words from a FIFO, optionally extracts
// white, and emits a self-clocked WS2812B/SK6812RGBW style bitstream.
module rgbw_sotp_gen
  import rgb_pkg::*;
#(
  parameter int unsigned T0H               = DEF_T0H,
  parameter int unsigned T0L               = DEF_T0L,
  parameter int unsigned T1H               = DEF_T1H,
  parameter int unsigned T1L               = DEF_T1L,
  parameter int unsigned STREAM_RESET_CLKS = DEF_STREAM_RESET_CLKS,
  parameter int unsigned OUT_MODE          = OUT_MODE_GRBW_EXTRACT
) (
  input logic             clk,
  input logic             rst_n,
  rgbw_sotp_gen_if.master led_if
);

  localparam int unsigned MAX_T = max_u(max_u(max_u(T0H, T0L), max_u(T1H, T1L)),
                                        STREAM_RESET_CLKS);
  localparam int unsigned CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] CntT0H = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] CntT0L = CNT_W'(T0L);
  localparam logic [CNT_W-1:0] CntT1H = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] CntT1L = CNT_W'(T1L);
  localparam logic [CNT_W-1:0] CntRst = CNT_W'(STREAM_RESET_CLKS);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  localparam logic       ExtractEn = (OUT_MODE == OUT_MODE_GRBW_EXTRACT);
  localparam logic [5:0] NumBits   = (OUT_MODE == OUT_MODE_GRB) ? 6'd24 : 6'd32;

  logic [1:0]       r_rst_sync;
  logic             w_run;

  sotp_state_e      r_state, w_state_d;
  logic [7:0]       r_g, r_r, r_b;
  logic [7:0]       w_g_d, w_r_d, w_b_d;
  logic [31:0]      r_shift, w_shift_d;
  logic [5:0]       r_bits_left, w_bits_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_sig, w_sig_d;
  logic             r_done, w_done_d;
  logic             w_rd_en;

  logic             w_fifo_empty;
  logic [31:0]      w_fifo_data;
  logic [7:0]       w_xg, w_xr, w_xb, w_xw;
  logic [31:0]      w_load_word;

  assign w_fifo_empty = led_if.in_rd_fifo_empty;
  assign w_fifo_data  = led_if.in_rd_fifo_data;

  rgbw_white_extract u_white_extract (
    .i_en (ExtractEn),
    .i_g  (r_g),
    .i_r  (r_r),
    .i_b  (r_b),
    .o_g  (w_xg),
    .o_r  (w_xr),
    .o_b  (w_xb),
    .o_w  (w_xw)
  );

  // Shift order is MSB-first G,R,B,W; in 24-bit mode the W byte is never reached.
  assign w_load_word = {w_xg, w_xr, w_xb, w_xw};

  // Two-flop release of the asynchronous reset; the FSM stays idle until it completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  // Next-state, datapath updates and the pop strobe.
  always_comb begin
    w_state_d = r_state;
    w_g_d     = r_g;
    w_r_d     = r_r;
    w_b_d     = r_b;
    w_shift_d = r_shift;
    w_bits_d  = r_bits_left;
    w_cnt_d   = r_cnt;
    w_sig_d   = r_sig;
    w_done_d  = 1'b0;
    w_rd_en   = 1'b0;
    case (r_state)
      StIdle: begin
        w_sig_d = 1'b0;
        if (!w_fifo_empty) begin
          w_rd_en   = 1'b1;
          w_state_d = StFetch;
        end
      end
      StFetch: begin
        // Stream reset wins over the valid flag.
        if (w_fifo_data[WORD_STRM_RST_BIT]) begin
          w_cnt_d   = CntRst;
          w_state_d = StStrmRst;
        end else if (!w_fifo_data[WORD_VALID_BIT]) begin
          w_state_d = StIdle;
        end else begin
          w_g_d     = w_fifo_data[WORD_G_MSB:WORD_G_LSB];
          w_r_d     = w_fifo_data[WORD_R_MSB:WORD_R_LSB];
          w_b_d     = w_fifo_data[WORD_B_MSB:WORD_B_LSB];
          w_state_d = StConvert;
        end
      end
      StConvert: begin
        w_shift_d = w_load_word;
        w_bits_d  = NumBits;
        w_cnt_d   = w_load_word[31] ? CntT1H : CntT0H;
        w_sig_d   = 1'b1;
        w_state_d = StSendH;
      end
      StSendH: begin
        if (r_cnt <= CntOne) begin
          w_cnt_d   = r_shift[31] ? CntT1L : CntT0L;
          w_sig_d   = 1'b0;
          w_state_d = StSendL;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StSendL: begin
        if (r_cnt <= CntOne) begin
          if (r_bits_left > 6'd1) begin
            w_shift_d = {r_shift[30:0], 1'b0};
            w_bits_d  = r_bits_left - 6'd1;
            w_cnt_d   = r_shift[30] ? CntT1H : CntT0H;
            w_sig_d   = 1'b1;
            w_state_d = StSendH;
          end else begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      StStrmRst: begin
        w_sig_d = 1'b0;
        if (r_cnt <= CntOne) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - CntOne;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_sig_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; cleared while reset is asserted or still releasing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_g         <= 8'h00;
      r_r         <= 8'h00;
      r_b         <= 8'h00;
      r_shift     <= 32'h0;
      r_bits_left <= 6'd0;
      r_cnt       <= '0;
      r_sig       <= 1'b0;
      r_done      <= 1'b0;
    end else if (!w_run) begin
      r_state     <= StIdle;
      r_g         <= 8'h00;
      r_r         <= 8'h00;
      r_b         <= 8'h00;
      r_shift     <= 32'h0;
      r_bits_left <= 6'd0;
      r_cnt       <= '0;
      r_sig       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_g         <= w_g_d;
      r_r         <= w_r_d;
      r_b         <= w_b_d;
      r_shift     <= w_shift_d;
      r_bits_left <= w_bits_d;
      r_cnt       <= w_cnt_d;
      r_sig       <= w_sig_d;
      r_done      <= w_done_d;
    end
  end

  assign led_if.out_rd_fifo_en = w_rd_en & w_run;
  assign led_if.out_sig        = r_sig;
  assign led_if.out_busy       = (r_state != StIdle);
  assign led_if.out_pixel_done = r_done;

endmodule

// File: tb/tb_rgbw_sotp_gen.sv
// Bench for rgbw_sotp_gen: a GRBW instance checked cycle-by-cycle against a
// waveform-expansion model, plus a GRB instance checked by decoded bitstream.
module tb_rgbw_sotp_gen;
  import rgb_pkg::*;

  localparam int T0H = 16;
  localparam int T0L = 74;
  localparam int T1H = 45;
  localparam int T1L = 45;
  localparam int SRC = 7681;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgbw_sotp_gen_if bus1 ();
  rgbw_sotp_gen_if bus0 ();

  rgbw_sotp_gen #(.T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .STREAM_RESET_CLKS(SRC),
                  .OUT_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .led_if(bus1.master));
  rgbw_sotp_gen #(.T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .STREAM_RESET_CLKS(SRC),
                  .OUT_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .led_if(bus0.master));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h required 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO emulation: pop request sampled mid-cycle, data presented after the edge.
  logic [31:0] fifo1[$];
  logic [31:0] fifo0[$];
  logic [31:0] mq[$];
  bit pop1_req, pop0_req;
  always @(negedge clk) begin
    pop1_req = bus1.out_rd_fifo_en;
    pop0_req = bus0.out_rd_fifo_en;
  end
  always @(posedge clk) begin
    #1;
    if (pop1_req && fifo1.size() > 0) bus1.in_rd_fifo_data = fifo1.pop_front();
    if (pop0_req && fifo0.size() > 0) bus0.in_rd_fifo_data = fifo0.pop_front();
    bus1.in_rd_fifo_empty = (fifo1.size() == 0);
    bus0.in_rd_fifo_empty = (fifo0.size() == 0);
  end

  task automatic push1(input logic [31:0] w);
    fifo1.push_back(w);
    mq.push_back(w);
    bus1.in_rd_fifo_empty = 1'b0;
  endtask

  task automatic push0(input logic [31:0] w);
    fifo0.push_back(w);
    bus0.in_rd_fifo_empty = 1'b0;
  endtask

  // Model: expected {sig, rd_en, busy, pixel_done} per cycle for the GRBW instance.
  logic [3:0] eq[$];
  bit pend_done = 0;
  int rel_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_cnt <= 0;
    else if (rel_cnt < 3) rel_cnt <= rel_cnt + 1;
  end

  task automatic expand(input logic [31:0] w, input bit d);
    int g, r, b, wh, hi, lo;
    logic [31:0] px;
    eq.push_back({3'b010, d});      // pop cycle
    eq.push_back(4'b0010);          // word arrives
    if (w[30]) begin
      for (int i = 0; i < SRC; i++) eq.push_back(4'b0010);
    end else if (w[31]) begin
      g  = int'(w[23:16]);
      r  = int'(w[15:8]);
      b  = int'(w[7:0]);
      wh = (g < r) ? g : r;
      wh = (wh < b) ? wh : b;
      px = {8'(g - wh), 8'(r - wh), 8'(b - wh), 8'(wh)};
      eq.push_back(4'b0010);        // conversion cycle
      for (int i = 31; i >= 0; i--) begin
        hi = px[i] ? T1H : T0H;
        lo = px[i] ? T1L : T0L;
        for (int k = 0; k < hi; k++) eq.push_back(4'b1010);
        for (int k = 0; k < lo; k++) eq.push_back(4'b0010);
      end
      pend_done = 1;
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    logic [31:0] w;
    bit d;
    if (!rst_n || rel_cnt < 2) begin
      eq.delete();
      pend_done = 0;
      e = 4'b0000;
    end else begin
      if (eq.size() == 0) begin
        d = pend_done;
        pend_done = 0;
        if (mq.size() > 0) begin
          w = mq.pop_front();
          expand(w, d);
        end else begin
          eq.push_back({3'b000, d});
        end
      end
      e = eq.pop_front();
    end
    check("cycle{sig,en,busy,done}",
          {60'd0, bus1.out_sig, bus1.out_rd_fifo_en, bus1.out_busy, bus1.out_pixel_done},
          {60'd0, e});
  end

  // Bitstream monitors.
  int lows1[$];
  int pops1[$];
  int hi1, lo1, nbits1, badhi1, done1, hi0, nbits0, done0;
  logic [63:0] bits1, bits0;
  logic prev1, prev0;

  task automatic clear_mon();
    lows1.delete();
    pops1.delete();
    hi1 = 0; lo1 = 0; nbits1 = 0; badhi1 = 0; done1 = 0; bits1 = '0;
    hi0 = 0; nbits0 = 0; done0 = 0; bits0 = '0;
  endtask

  always @(negedge clk) begin
    if (bus1.out_rd_fifo_en) pops1.push_back(cyc);
    if (bus1.out_pixel_done) done1++;
    if (bus1.out_sig) begin
      if (!prev1) lows1.push_back(lo1);
      hi1++;
      lo1 = 0;
    end else begin
      if (prev1) begin
        bits1 = {bits1[62:0], hi1 == T1H};
        nbits1++;
        if (hi1 != T1H && hi1 != T0H) badhi1++;
      end
      hi1 = 0;
      lo1++;
    end
    prev1 = bus1.out_sig;
    if (bus0.out_pixel_done) done0++;
    if (bus0.out_sig) begin
      hi0++;
    end else begin
      if (prev0) begin
        bits0 = {bits0[62:0], hi0 == T1H};
        nbits0++;
      end
      hi0 = 0;
    end
    prev0 = bus0.out_sig;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int snap;
    prev1 = 0; prev0 = 0;
    clear_mon();
    bus1.in_rd_fifo_empty = 1'b1;
    bus0.in_rd_fifo_empty = 1'b1;
    bus1.in_rd_fifo_data  = '0;
    bus0.in_rd_fifo_data  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(3);
    check("rst_sig",  {63'd0, bus1.out_sig}, 64'd0);
    check("rst_busy", {63'd0, bus1.out_busy}, 64'd0);
    check("rst_en",   {63'd0, bus1.out_rd_fifo_en}, 64'd0);
    check("rst_done", {63'd0, bus1.out_pixel_done}, 64'd0);
    rst_n = 1'b1;
    tick(5);

    // GRBW extraction on one instance, GRB pass-through on the other.
    clear_mon();
    push1(32'h80102030);
    push0(32'h80FF00AA);
    for (int i = 0; i < 4000 && (done1 == 0 || done0 == 0); i++) tick(1);
    tick(5);
    check("t1_done", 64'(done1), 64'd1);
    check("t1_nbits", 64'(nbits1), 64'd32);
    check("t1_bits", bits1, 64'h0000_0000_0010_2010);
    check("t1_highs", 64'(badhi1), 64'd0);
    check("t2_done", 64'(done0), 64'd1);
    check("t2_nbits", 64'(nbits0), 64'd24);
    check("t2_bits", bits0, 64'h0000_0000_00FF_00AA);
    tick(20);
    check("t2_sig_low", {63'd0, bus0.out_sig}, 64'd0);
    check("t2_idle", {63'd0, bus0.out_busy}, 64'd0);

    // Stream reset word followed by an invalid word.
    clear_mon();
    push1(32'h40000000);
    push1(32'h00000000);
    for (int i = 0; i < 9000 && pops1.size() < 2; i++) tick(1);
    tick(5);
    check("t3_pops", 64'(pops1.size()), 64'd2);
    if (pops1.size() >= 2) check("t3_gap", 64'(pops1[1] - pops1[0]), 64'd7683);
    check("t3_nbits", 64'(nbits1), 64'd0);

    // Invalid word discarded, next pop two clocks later.
    clear_mon();
    push1(32'h00123456);
    push1(32'h80000000);
    for (int i = 0; i < 4000 && done1 == 0; i++) tick(1);
    tick(3);
    check("t4_pops", 64'(pops1.size()), 64'd2);
    if (pops1.size() >= 2) check("t4_gap", 64'(pops1[1] - pops1[0]), 64'd2);
    check("t4_nbits", 64'(nbits1), 64'd32);
    check("t4_bits", bits1, 64'd0);

    // Back-to-back pixels: last low of pixel 1 stretched by three clocks.
    clear_mon();
    push1(32'h80010203);
    push1(32'h80FFFFFF);
    for (int i = 0; i < 8000 && done1 < 2; i++) tick(1);
    tick(20);
    check("t5_done", 64'(done1), 64'd2);
    check("t5_bits", bits1, 64'h0001_0201_0000_00FF);
    check("t5_lows", 64'(lows1.size() >= 33), 64'd1);
    if (lows1.size() >= 33) check("t5_gap_low", 64'(lows1[32]), 64'(T1L + 3));
    check("t5_idle", {62'd0, bus1.out_busy, bus1.out_sig}, 64'd0);

    // Reset pulse during the high phase of bit 10.
    clear_mon();
    push1(32'h80FF0000);
    for (int i = 0; i < 2000 && !(nbits1 == 9 && bus1.out_sig); i++) tick(1);
    check("t6_reached", {63'd0, bus1.out_sig}, 64'd1);
    rst_n = 1'b0;
    #2;
    check("t6_sig_now", {63'd0, bus1.out_sig}, 64'd0);
    check("t6_busy_now", {63'd0, bus1.out_busy}, 64'd0);
    #3 rst_n = 1'b1;
    tick(2);
    snap = nbits1;
    pops1.delete();
    tick(200);
    check("t6_no_bits", 64'(nbits1), 64'(snap));
    check("t6_no_pop", 64'(pops1.size()), 64'd0);
    check("t6_idle", {62'd0, bus1.out_busy, bus1.out_sig}, 64'd0);
    done1 = 0;
    push1(32'h80000000);
    for (int i = 0; i < 4000 && done1 == 0; i++) tick(1);
    tick(3);
    check("t6_pop_after", 64'(pops1.size()), 64'd1);
    check("t6_done_after", 64'(done1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
